// File: rtl/mux2_arbiter.sv
// Round-robin, burst-locked arbiter that shares one WIDTH-bit datapath between
// two valid/ready requesters through a single registered output stage.

module mux_2x1 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = sel_i ? d1_i : d0_i;
endmodule

module mux2_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [1:0]       gnt,
    output logic             busy
);
    localparam int unsigned      CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;

    logic             space;
    logic             sel;
    logic             xfer0;
    logic             xfer1;
    logic             release_own;
    logic [WIDTH-1:0] mux_y;

    assign sel       = (state_q == OWN1);
    assign space     = !out_valid_q || out_ready;
    assign in0_ready = (state_q == OWN0) && space;
    assign in1_ready = (state_q == OWN1) && space;
    assign xfer0     = in0_valid && in0_ready;
    assign xfer1     = in1_valid && in1_ready;

    mux_2x1 #(.WIDTH(WIDTH)) u_mux (
        .sel_i (sel),
        .d0_i  (in0_data),
        .d1_i  (in1_data),
        .y_o   (mux_y)
    );

    // A released owner hands straight to a waiting peer, otherwise drops to
    // IDLE, so it can never re-grant itself without an idle cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        release_own = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in0_valid && (!in1_valid || last_q)) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end else if (in1_valid) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            OWN0: begin
                if (!in0_valid) begin
                    release_own = 1'b1;
                end else if (xfer0) begin
                    if (cnt_q == CNT_LAST) release_own = 1'b1;
                    else                   cnt_d = cnt_q + CNT_W'(1);
                end
                if (release_own) begin
                    cnt_d = '0;
                    if (in1_valid) begin
                        state_d = OWN1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            OWN1: begin
                if (!in1_valid) begin
                    release_own = 1'b1;
                end else if (xfer1) begin
                    if (cnt_q == CNT_LAST) release_own = 1'b1;
                    else                   cnt_d = cnt_q + CNT_W'(1);
                end
                if (release_own) begin
                    cnt_d = '0;
                    if (in0_valid) begin
                        state_d = OWN0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (xfer0 || xfer1) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_y;
            out_src_d   = xfer1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign gnt       = {state_q == OWN1, state_q == OWN0};
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/mux2_arbiter.md
# mux2_arbiter

Round-robin, burst-locked arbiter that shares one WIDTH-bit datapath between two valid/ready requesters. It steers an internal mux_2x1 with its grant, registers the selected beat into one output stage, and presents it downstream with a valid/ready handshake. It sits in front of any shared single-port resource in the processor, such as a memory write port or a register-file write port fed from two sources.

## Interface
- WIDTH, 32, data width of every data port
- MAX_BURST, 4, maximum beats one requester may transfer per grant (legal range ≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in0_valid  in  1  requester 0 has a beat
- in0_data  in  WIDTH  requester 0 beat
- in0_ready  out  1  requester 0 beat accepted this cycle
- in1_valid  in  1  requester 1 has a beat
- in1_data  in  WIDTH  requester 1 beat
- in1_ready  out  1  requester 1 beat accepted this cycle
- out_valid  out  1  out_data holds a beat
- out_data  out  WIDTH  registered beat
- out_src  out  1  source index of out_data
- out_ready  in  1  downstream accepts the beat
- gnt  out  2  one-hot current owner; 00 means idle
- busy  out  1  state is not IDLE

## Operation
- Decided interface: one clock (clk); reset rst_n is synchronous and active-low.
- State registers:
  - state ∈ {IDLE, OWN0, OWN1}
  - cnt, $clog2(MAX_BURST) bits with a minimum of 1, counts beats in the current grant
  - last, the most recent owner
- gnt = {state==OWN1, state==OWN0}, decoded from state. Mux select = (state==OWN1).
- space = !out_valid || out_ready.
- ink_ready = (state==OWNk) && space.
- A transfer on requester k is ink_valid && ink_ready. On a transfer:
  - out_data ← mux output, out_src ← k, out_valid ← 1.
  - A simultaneous downstream pop and transfer keeps out_valid at 1 and replaces the data.
  - A pop with no transfer clears out_valid.
- IDLE:
  - Only one valid → OWN of that requester.
  - Both valid → OWN(1−last).
  - Neither valid → stay in IDLE.
  - On entering OWNk: last ← k, cnt ← 0.
- OWNk, release conditions (evaluated in priority order):
  - (a) ink_valid==0: release. No beat is lost, because ready only matters when valid is high.
  - (b) A transfer with cnt==MAX_BURST−1: release after that beat.
  - Otherwise a transfer increments cnt, and a stall (valid high, not ready) holds cnt.
- Release handoff:
  - If in(1−k)_valid is high → OWN(1−k), last ← 1−k, cnt ← 0.
  - Else → IDLE, cnt ← 0.
  - A released owner never re-grants itself directly; it must pass through IDLE.
- Protocol rules for requesters (assertion-checked in the bench, not in RTL):
  - Once valid is raised, hold it and hold data stable until ready.
  - Valid may drop only after a transfer.
- Reset (rst_n==0 at an edge) forces:
  - state=IDLE, cnt=0, last=1 (requester 0 wins the first tie)
  - out_valid=0, out_data=0, out_src=0
  - gnt=00, busy=0, in0_ready=in1_ready=0
- Reset mid-burst discards the held output beat.

## Timing
- Arbitration latency: valid raised in cycle N while IDLE → gnt set in N+1 → ready high in N+1 when space allows → out_valid in N+2.
- Handoff between requesters costs no bubble. A return through IDLE costs one idle cycle.
- Throughput is 1 beat/cycle while out_ready stays high.
- A stalled output (out_valid=1, out_ready=0) drops both readies in the same cycle. out_data and out_src are then held.
- All outputs are registered or decoded from registers only; there is no input-to-output combinational path except out_ready → ink_ready.
- MAX_BURST=1: every beat releases, so under contention the owners alternate every beat.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with both valids high → all outputs zero. First edge after release: gnt=01, out_src=0 on first beat.
- Single requester: in0 sends 0x10..0x15 (6 beats), out_ready=1, MAX_BURST=4 →
  - beats 0x10..0x13, then one idle cycle (gnt=00), then 0x14,0x15
  - out_valid first seen 2 cycles after in0_valid
- Contention: both valid continuously, in0 data 0xA0+n, in1 data 0xB0+n →
  - out sequence A0–A3, B0–B3, A4–A7
  - gnt switches with no bubble; out_src matches
- Backpressure: out_ready=0 for 5 cycles mid-burst →
  - out_data frozen, both readies 0, cnt frozen
  - burst resumes with the remaining beats only; no loss or duplication
- Early drop: in1 valid for 2 beats and then low, in0 valid → in1 released after 2 beats, immediate handoff to in0.
- Reset mid-operation: assert rst_n=0 while out_valid=1 in OWN1 → next cycle out_valid=0, state IDLE, last=1.
